coherence_bus_controller: RTL and testbench
===========================================

Name: coherence_bus_controller

Overview:
- Memory-side bus controller between both cores' cache pairs (icache and dcache per core) and the single-ported RAM.
- Arbitrates dcache writebacks, dcache fills and icache fetches.
- Runs a snoop/invalidate handshake against the non-requesting dcache.
- When the snooped dcache holds the block dirty, performs a cache-to-cache transfer and updates RAM with the same data.

Parameters:
- CPUS, 2, number of cores. Fixed at 2; the round-robin pointer is 1 bit.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  2  icache read request, per core
- iaddr  in  64  icache word address, 32 bits per core ([31:0] = core 0)
- iwait  out  2  icache stall, per core
- iload  out  64  icache read data, 32 bits per core
- dREN  in  2  dcache read (fill) request
- dWEN  in  2  dcache write (writeback) request
- daddr  in  64  dcache word address, per core
- dstore  in  64  dcache write data / cache-to-cache supply data, per core
- dwait  out  2  dcache stall, per core
- dload  out  64  dcache read data, per core
- ccwrite  in  2  as requester: fill is for write (BusRdX); as snoopee: block held Modified
- cctrans  in  2  as requester: coherence transaction; as snoopee: snoop acknowledge
- ccwait  out  2  snoop in progress on this core's dcache
- ccinv  out  2  invalidate the snooped block
- ccsnoopaddr  out  64  snoop address, per core
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR; a word completes in the cycle ramstate==ACCESS

Behaviour:
Reset:
- state=IDLE, rr=0.
- dwait=2'b11, iwait=2'b11.
- ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore = 0.
- Reset asserted mid-transaction aborts it: RAM strobes drop asynchronously and no grant is remembered.

Defaults (every state):
- dwait=iwait=2'b11; dload[c]=iload[c]=ramload for both cores.

Arbitration (IDLE only), strict priority dWEN > dREN > iREN:
- Within a class, if both cores request, grant core rr; otherwise grant the sole requester.
- Granted core r is latched; o = ~r. rr <= o on every grant.
- IDLE issues no RAM strobes; a grant takes one cycle before the first RAM access.

State machine:
- IDLE -> WB1 on dWEN grant; -> SNOOP on dREN grant; -> IFETCH on iREN grant; else stay.
- WB1/WB2:
  - ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r].
  - On ACCESS: dwait[r]=0. WB1 -> WB2; WB2 -> IDLE.
- SNOOP:
  - ccwait[o]=1, ccsnoopaddr[o]=daddr[r], ccinv[o]=ccwrite[r].
  - Waits until cctrans[o]=1.
  - Then -> C2C1 if ccwrite[o]=1 (dirty copy); else -> LOAD1.
- C2C1/C2C2:
  - ccwait[o]=1, ccinv[o] held.
  - ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[r]=dstore[o].
  - On ACCESS: dwait[r]=0 and dwait[o]=0, both caches advance a word. C2C1 -> C2C2 -> IDLE.
- LOAD1/LOAD2:
  - ccwait[o]=1 held through LOAD2 so the snoopee cannot race.
  - ramREN=1, ramaddr=daddr[r].
  - On ACCESS: dwait[r]=0. LOAD1 -> LOAD2 -> IDLE.
- IFETCH:
  - ramREN=1, ramaddr=iaddr[r].
  - On ACCESS: iwait[r]=0, -> IDLE.
- Requester advances its own daddr word offset (0 then 4) between words; the controller uses daddr as presented.

Boundary conditions:
- ramstate BUSY or FREE: hold the state, all wait lines stay 1.
- ramstate ERROR: treated as BUSY (retry).
- Requests arriving mid-transaction are ignored until IDLE.
- A request dropped before service is simply not granted.
- Simultaneous dWEN[0] and dREN[1]: the writeback wins regardless of rr.
- ccinv is asserted only with ccwait.

Test Plan:
- dcache0 dREN, daddr0=0x100 then 0x104, ccwrite0=0; core1 acks cctrans1=1, ccwrite1=0; RAM holds 0xAAAA/0xBBBB → ccsnoopaddr1=0x100, ccinv1=0, dload0=0xAAAA then 0xBBBB, dwait0 low one cycle per ACCESS, ccwait1 low only after LOAD2.
- dcache0 BusRdX (ccwrite0=1) to 0x200; core1 acks with ccwrite1=1, dstore1=0x1111 then 0x2222 → ccinv1=1, dload0=0x1111/0x2222, RAM writes 0x200=0x1111 and 0x204=0x2222, dwait0 and dwait1 drop together.
- dWEN0 and dREN1 raised in the same cycle → WB1/WB2 for core 0 first, then SNOOP for core 1.
- iREN0 and iREN1 repeatedly, rr=0 → grants alternate core0, core1, core0; iload[r]=ramload at ACCESS.
- ramstate=BUSY for 3 cycles in LOAD1 → state held, dwait0=1 throughout, word delivered on the ACCESS cycle.
- nRST pulsed during C2C2 → all outputs at reset values immediately, next grant from IDLE with rr=0.

Source files
------------

// File: rtl/coherence_bus_controller.sv
// Memory-side bus controller for two cores: arbitrates dcache writebacks, fills and icache fetches
// onto a single-ported RAM, with snoop/invalidate and dirty cache-to-cache transfer.
module coherence_bus_controller #(
    parameter int unsigned CPUS = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*32-1:0]   iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS*32-1:0]   iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   dload,
    input  logic [CPUS-1:0]      ccwrite,
    input  logic [CPUS-1:0]      cctrans,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [CPUS*32-1:0]   ccsnoopaddr,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
);

    typedef enum logic [3:0] {
        StIdle, StWb1, StWb2, StSnoop, StC2c1, StC2c2, StLoad1, StLoad2, StIfetch
    } state_e;

    state_e state_q;
    logic   r_q;
    logic   rr_q;
    logic   inv_q;
    logic   o;
    logic   access;

    logic [5:0]  r_base;
    logic [5:0]  o_base;
    logic [31:0] daddr_r;
    logic [31:0] daddr_o;
    logic [31:0] dstore_r;
    logic [31:0] dstore_o;
    logic [31:0] iaddr_r;

    logic   gnt_valid;
    logic   gnt_core;
    state_e gnt_state;

    assign o      = ~r_q;
    assign access = (ramstate == 2'b10);
    assign r_base = {r_q, 5'd0};
    assign o_base = {o, 5'd0};

    assign daddr_r  = daddr[r_base +: 32];
    assign daddr_o  = daddr[o_base +: 32];
    assign dstore_r = dstore[r_base +: 32];
    assign dstore_o = dstore[o_base +: 32];
    assign iaddr_r  = iaddr[r_base +: 32];

    // Both requesting: take the round-robin core; otherwise the sole requester.
    function automatic logic pick(input logic [1:0] req, input logic rr);
        return (&req) ? rr : req[1];
    endfunction

    always_comb begin
        gnt_valid = 1'b1;
        gnt_core  = 1'b0;
        gnt_state = StIdle;
        if (|dWEN) begin
            gnt_core  = pick(dWEN, rr_q);
            gnt_state = StWb1;
        end else if (|dREN) begin
            gnt_core  = pick(dREN, rr_q);
            gnt_state = StSnoop;
        end else if (|iREN) begin
            gnt_core  = pick(iREN, rr_q);
            gnt_state = StIfetch;
        end else begin
            gnt_valid = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            r_q     <= 1'b0;
            rr_q    <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        state_q <= gnt_state;
                        r_q     <= gnt_core;
                        rr_q    <= ~gnt_core;
                    end
                end
                StWb1:    if (access) state_q <= StWb2;
                StWb2:    if (access) state_q <= StIdle;
                StSnoop: begin
                    if (cctrans[o]) begin
                        inv_q   <= ccwrite[r_q];
                        state_q <= ccwrite[o] ? StC2c1 : StLoad1;
                    end
                end
                StC2c1:   if (access) state_q <= StC2c2;
                StC2c2:   if (access) state_q <= StIdle;
                StLoad1:  if (access) state_q <= StLoad2;
                StLoad2:  if (access) state_q <= StIdle;
                StIfetch: if (access) state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        dwait       = 2'b11;
        iwait       = 2'b11;
        dload       = {ramload, ramload};
        iload       = {ramload, ramload};
        ccwait      = 2'b00;
        ccinv       = 2'b00;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = 32'd0;
        ramstore    = 32'd0;
        case (state_q)
            StWb1, StWb2: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr_r;
                ramstore = dstore_r;
                if (access) dwait[r_q] = 1'b0;
            end
            StSnoop: begin
                ccwait[o]                = 1'b1;
                ccinv[o]                 = ccwrite[r_q];
                ccsnoopaddr[o_base +: 32] = daddr_r;
            end
            StC2c1, StC2c2: begin
                // Snoopee supplies the block; RAM is updated with the same word.
                ccwait[o]             = 1'b1;
                ccinv[o]              = inv_q;
                ramWEN                = 1'b1;
                ramaddr               = daddr_o;
                ramstore              = dstore_o;
                dload[r_base +: 32]   = dstore_o;
                if (access) dwait = 2'b00;
            end
            StLoad1, StLoad2: begin
                ccwait[o] = 1'b1;
                ramREN    = 1'b1;
                ramaddr   = daddr_r;
                if (access) dwait[r_q] = 1'b0;
            end
            StIfetch: begin
                ramREN  = 1'b1;
                ramaddr = iaddr_r;
                if (access) iwait[r_q] = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_controller.sv
// Directed bench for coherence_bus_controller: snoop fills, cache-to-cache, priority, stalls,
// mid-transaction reset and round-robin icache arbitration.
module tb_coherence_bus_controller;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  iREN;
    logic [63:0] iaddr;
    logic [1:0]  iwait;
    logic [63:0] iload;
    logic [1:0]  dREN;
    logic [1:0]  dWEN;
    logic [63:0] daddr;
    logic [63:0] dstore;
    logic [1:0]  dwait;
    logic [63:0] dload;
    logic [1:0]  ccwrite;
    logic [1:0]  cctrans;
    logic [1:0]  ccwait;
    logic [1:0]  ccinv;
    logic [63:0] ccsnoopaddr;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] Free = 2'b00, Busy = 2'b01, Access = 2'b10, Error = 2'b11;

    coherence_bus_controller #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_inputs;
        iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
        ccwrite = 0; cctrans = 0; ramload = 0; ramstate = Free;
    endtask

    task automatic test_reset;
        clear_inputs();
        nRST = 1'b0;
        #3;
        checks++; if (dwait !== 2'b11) begin failures++; $display("FAIL rst_dwait got=%b exp=11", dwait); end
        checks++; if (iwait !== 2'b11) begin failures++; $display("FAIL rst_iwait got=%b exp=11", iwait); end
        checks++; if ({ramREN, ramWEN, ccwait, ccinv} !== 6'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=0", {ramREN, ramWEN, ccwait, ccinv}); end
        checks++; if ({ramaddr, ramstore, ccsnoopaddr} !== 128'b0) begin failures++; $display("FAIL rst_buses got=%h exp=0", {ramaddr, ramstore, ccsnoopaddr}); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_snoop_load;
        tick();
        dREN = 2'b01; daddr = {32'h0, 32'h100};
        #1;
        checks++; if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("FAIL ld_idle_strobe got=%b exp=00", {ramREN, ramWEN}); end
        tick();
        checks++; if (ccwait !== 2'b10) begin failures++; $display("FAIL ld_snoop_ccwait got=%b exp=10", ccwait); end
        checks++; if (ccsnoopaddr[63:32] !== 32'h100) begin failures++; $display("FAIL ld_snoopaddr got=%h exp=100", ccsnoopaddr[63:32]); end
        checks++; if (ccinv !== 2'b00) begin failures++; $display("FAIL ld_ccinv got=%b exp=00", ccinv); end
        checks++; if (dwait !== 2'b11) begin failures++; $display("FAIL ld_snoop_dwait got=%b exp=11", dwait); end
        cctrans = 2'b10; ccwrite = 2'b00;
        tick();
        cctrans = 2'b00; ramstate = Access; ramload = 32'hAAAA;
        #1;
        checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h100}) begin failures++; $display("FAIL ld1_ram got=%b/%h exp=1/100", ramREN, ramaddr); end
        checks++; if (dwait !== 2'b10) begin failures++; $display("FAIL ld1_dwait got=%b exp=10", dwait); end
        checks++; if (dload[31:0] !== 32'hAAAA) begin failures++; $display("FAIL ld1_dload got=%h exp=aaaa", dload[31:0]); end
        checks++; if (ccwait !== 2'b10) begin failures++; $display("FAIL ld1_ccwait got=%b exp=10", ccwait); end
        tick();
        daddr = {32'h0, 32'h104}; ramload = 32'hBBBB;
        #1;
        checks++; if (ramaddr !== 32'h104) begin failures++; $display("FAIL ld2_addr got=%h exp=104", ramaddr); end
        checks++; if ({dwait, dload[31:0]} !== {2'b10, 32'hBBBB}) begin failures++; $display("FAIL ld2_data got=%b/%h exp=10/bbbb", dwait, dload[31:0]); end
        checks++; if (ccwait !== 2'b10) begin failures++; $display("FAIL ld2_ccwait got=%b exp=10", ccwait); end
        dREN = 2'b00;
        tick();
        checks++; if ({ccwait, dwait} !== 4'b0011) begin failures++; $display("FAIL ld_done got=%b exp=0011", {ccwait, dwait}); end
        ramstate = Free;
    endtask

    task automatic test_busy;
        dREN = 2'b01; daddr = {32'h0, 32'h300};
        tick();
        cctrans = 2'b10;
        tick();
        cctrans = 2'b00; ramstate = Busy;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({dwait, ramREN, ramaddr} !== {2'b11, 1'b1, 32'h300}) begin failures++; $display("FAIL busy_hold%0d got=%b/%b/%h exp=11/1/300", i, dwait, ramREN, ramaddr); end
            tick();
        end
        ramstate = Error;
        #1;
        checks++; if (dwait !== 2'b11) begin failures++; $display("FAIL busy_error got=%b exp=11", dwait); end
        tick();
        ramstate = Access; ramload = 32'hCCCC;
        #1;
        checks++; if ({dwait, dload[31:0], ramaddr} !== {2'b10, 32'hCCCC, 32'h300}) begin failures++; $display("FAIL busy_deliver got=%b/%h/%h exp=10/cccc/300", dwait, dload[31:0], ramaddr); end
        tick();
        daddr = {32'h0, 32'h304};
        #1;
        checks++; if (ramaddr !== 32'h304) begin failures++; $display("FAIL busy_ld2 got=%h exp=304", ramaddr); end
        dREN = 2'b00;
        tick();
        ramstate = Free;
    endtask

    task automatic test_c2c;
        dREN = 2'b01; ccwrite = 2'b01; daddr = {32'h0, 32'h200};
        tick();
        checks++; if ({ccwait, ccinv} !== 4'b1010) begin failures++; $display("FAIL c2c_snoop got=%b exp=1010", {ccwait, ccinv}); end
        cctrans = 2'b10; ccwrite = 2'b11; daddr = {32'h200, 32'h200}; dstore = {32'h1111, 32'h0};
        tick();
        cctrans = 2'b00; ramstate = Access;
        #1;
        checks++; if ({ramWEN, ramaddr, ramstore} !== {1'b1, 32'h200, 32'h1111}) begin failures++; $display("FAIL c2c1_ram got=%b/%h/%h exp=1/200/1111", ramWEN, ramaddr, ramstore); end
        checks++; if (dload[31:0] !== 32'h1111) begin failures++; $display("FAIL c2c1_dload got=%h exp=1111", dload[31:0]); end
        checks++; if ({dwait, ccwait, ccinv} !== 6'b001010) begin failures++; $display("FAIL c2c1_ctl got=%b exp=001010", {dwait, ccwait, ccinv}); end
        tick();
        daddr = {32'h204, 32'h204}; dstore = {32'h2222, 32'h0};
        #1;
        checks++; if ({ramaddr, ramstore, dload[31:0]} !== {32'h204, 32'h2222, 32'h2222}) begin failures++; $display("FAIL c2c2_data got=%h/%h/%h exp=204/2222/2222", ramaddr, ramstore, dload[31:0]); end
        checks++; if ({dwait, ccinv} !== 4'b0010) begin failures++; $display("FAIL c2c2_ctl got=%b exp=0010", {dwait, ccinv}); end
        dREN = 2'b00; ccwrite = 2'b00;
        tick();
        checks++; if ({ccwait, ccinv, ramWEN} !== 5'b0) begin failures++; $display("FAIL c2c_done got=%b exp=0", {ccwait, ccinv, ramWEN}); end
        ramstate = Free;
    endtask

    task automatic test_priority;
        dWEN = 2'b01; dREN = 2'b10; daddr = {32'h800, 32'h400}; dstore = {32'h0, 32'hD0};
        tick();
        ramstate = Access;
        #1;
        checks++; if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h400, 32'hD0}) begin failures++; $display("FAIL pri_wb1 got=%b%b/%h/%h exp=10/400/d0", ramWEN, ramREN, ramaddr, ramstore); end
        checks++; if ({dwait, ccwait} !== 4'b1000) begin failures++; $display("FAIL pri_wb1_wait got=%b exp=1000", {dwait, ccwait}); end
        tick();
        daddr = {32'h800, 32'h404}; dstore = {32'h0, 32'hD4};
        #1;
        checks++; if ({ramaddr, ramstore, dwait} !== {32'h404, 32'hD4, 2'b10}) begin failures++; $display("FAIL pri_wb2 got=%h/%h/%b exp=404/d4/10", ramaddr, ramstore, dwait); end
        dWEN = 2'b00;
        tick();
        checks++; if ({ramWEN, ramREN, dwait} !== 4'b0011) begin failures++; $display("FAIL pri_idle got=%b exp=0011", {ramWEN, ramREN, dwait}); end
        tick();
        checks++; if ({ccwait, ccsnoopaddr} !== {2'b01, 32'h0, 32'h800}) begin failures++; $display("FAIL pri_snoop got=%b/%h exp=01/0000000000000800", ccwait, ccsnoopaddr); end
        cctrans = 2'b01;
        tick();
        cctrans = 2'b00; dREN = 2'b00;
        #1;
        checks++; if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h800, 2'b01}) begin failures++; $display("FAIL pri_ld1 got=%b/%h/%b exp=1/800/01", ramREN, ramaddr, dwait); end
        tick();
        tick();
        ramstate = Free;
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        dREN = 2'b01; ccwrite = 2'b01; daddr = {32'h700, 32'h700}; dstore = {32'h77, 32'h0};
        tick();
        cctrans = 2'b10; ccwrite = 2'b11;
        tick();
        cctrans = 2'b00; ramstate = Access;
        tick();
        ramstate = Busy;
        #1;
        checks++; if ({ramWEN, ccwait} !== 3'b110) begin failures++; $display("FAIL mid_pre got=%b exp=110", {ramWEN, ccwait}); end
        nRST = 1'b0;
        #1;
        checks++; if ({ramWEN, ramREN, ccwait, ccinv, dwait, iwait} !== 10'b0000001111) begin failures++; $display("FAIL mid_reset got=%b exp=0000001111", {ramWEN, ramREN, ccwait, ccinv, dwait, iwait}); end
        checks++; if ({ramaddr, ramstore} !== 64'h0) begin failures++; $display("FAIL mid_reset_bus got=%h/%h exp=0/0", ramaddr, ramstore); end
        clear_inputs();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_rr_ifetch;
        iREN = 2'b11; iaddr = {32'h600, 32'h500}; ramstate = Access; ramload = 32'h55;
        tick();
        checks++; if ({ramREN, ramaddr} !== {1'b1, 32'h500}) begin failures++; $display("FAIL rr_g0 got=%b/%h exp=1/500", ramREN, ramaddr); end
        checks++; if ({iwait, iload[31:0]} !== {2'b10, 32'h55}) begin failures++; $display("FAIL rr_g0_data got=%b/%h exp=10/55", iwait, iload[31:0]); end
        tick();
        checks++; if ({iwait, ramREN} !== 3'b110) begin failures++; $display("FAIL rr_idle got=%b exp=110", {iwait, ramREN}); end
        ramload = 32'h66;
        tick();
        checks++; if ({ramaddr, iwait, iload[63:32]} !== {32'h600, 2'b01, 32'h66}) begin failures++; $display("FAIL rr_g1 got=%h/%b/%h exp=600/01/66", ramaddr, iwait, iload[63:32]); end
        tick();
        tick();
        checks++; if ({ramaddr, iwait} !== {32'h500, 2'b10}) begin failures++; $display("FAIL rr_g2 got=%h/%b exp=500/10", ramaddr, iwait); end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_snoop_load();
        test_busy();
        test_c2c();
        test_priority();
        test_reset_mid();
        test_rr_ifetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
